// File: rtl/seg_595_scan_if.sv
// Application-side and 74HC595 pin bundle for the scanned display driver.
// The application drives the display fields; the driver drives the pins.
interface seg_595_scan_if #(
   parameter int DIGITS = 6
);
   logic [4*DIGITS-1:0] data;
   logic [DIGITS-1:0]   point;
   logic                lz_en;
   logic                disp_en;
   logic                ds;
   logic                shcp;
   logic                stcp;
   logic                oe;

   modport master (
      output data, point, lz_en, disp_en,
      input  ds, shcp, stcp, oe
   );

   modport slave (
      input  data, point, lz_en, disp_en,
      output ds, shcp, stcp, oe
   );
endinterface

// File: rtl/seg_595_scan.sv
// Dynamic-scan driver for an N-digit 8-segment display behind a 74HC595 chain:
// one digit per scan tick, {seg, sel} shifted MSB first, then a storage pulse.
module seg_595_scan #(
   parameter int DIGITS         = 6,
   parameter int SCAN_CNT_MAX   = 49_999,
   parameter int SHCP_DIV       = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit SEL_ACTIVE_LOW = 1'b0
) (
   input logic           sys_clk,
   input logic           sys_rst_n,
   seg_595_scan_if.slave bus
);
   localparam int W    = DIGITS + 8;
   localparam int K_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int B_W  = $clog2(W);
   localparam int SC_W = (SCAN_CNT_MAX > 0) ? $clog2(SCAN_CNT_MAX + 1) : 1;
   localparam int DV_W = $clog2(SHCP_DIV + 1);
   localparam logic [SC_W-1:0] SCAN_LAST = SC_W'(SCAN_CNT_MAX);
   localparam logic [DV_W-1:0] DIV_LAST  = DV_W'(SHCP_DIV - 1);
   localparam logic [K_W-1:0]  K_LAST    = K_W'(DIGITS - 1);
   localparam logic [B_W-1:0]  BIT_TOP   = B_W'(W - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2,
      LATCH    = 2'd3
   } state_t;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   state_t          state_r, state_nxt_s;
   logic [SC_W-1:0] scan_cnt_r;
   logic [DV_W-1:0] div_cnt_r, div_nxt_s;
   logic [B_W-1:0]  bit_r, bit_nxt_s;
   logic [K_W-1:0]  k_r, k_nxt_s;
   logic [W-1:0]    frame_r, frame_nxt_s, frame_s;
   logic            ds_r, shcp_r, stcp_r, oe_r, armed_r;
   logic            ds_nxt_s, shcp_nxt_s, stcp_nxt_s, oe_nxt_s, armed_nxt_s;
   logic            tick_s, div_done_s, upper_zero_s;
   logic [DIGITS-1:0] sel_s;
   logic [3:0]      nibble_s;
   logic [7:0]      seg_hi_s, seg_s;

   assign tick_s     = (scan_cnt_r == SCAN_LAST);
   assign div_done_s = (div_cnt_r == DIV_LAST);

   // Frame word for digit k_r, built from the live inputs and captured at frame start.
   always_comb begin
      upper_zero_s = 1'b1;
      sel_s        = {DIGITS{1'b0}};
      for (int i = 0; i < DIGITS; i++) begin
         upper_zero_s = upper_zero_s & ~((K_W'(i) >= k_r) & (|bus.data[4*i +: 4]));
         sel_s[i]     = (K_W'(i) == k_r);
      end
      nibble_s = bus.data[{k_r, 2'b00} +: 4];
      if (bus.lz_en && (k_r != {K_W{1'b0}}) && upper_zero_s) begin
         seg_hi_s = {bus.point[k_r], 7'h00};
      end else begin
         seg_hi_s = {bus.point[k_r], hex_to_seg(nibble_s)};
      end
      seg_s   = SEG_ACTIVE_LOW ? ~seg_hi_s : seg_hi_s;
      frame_s = {seg_s, (SEL_ACTIVE_LOW ? ~sel_s : sel_s)};
   end

   // Next state plus pin values derived from the next state so the pins are pure flops.
   always_comb begin
      state_nxt_s = state_r;
      div_nxt_s   = div_cnt_r;
      bit_nxt_s   = bit_r;
      k_nxt_s     = k_r;
      frame_nxt_s = frame_r;
      case (state_r)
         IDLE: begin
            if (tick_s) begin
               state_nxt_s = SHIFT_LO;
               div_nxt_s   = {DV_W{1'b0}};
               bit_nxt_s   = BIT_TOP;
               frame_nxt_s = frame_s;
               k_nxt_s     = (k_r == K_LAST) ? {K_W{1'b0}} : k_r + {{(K_W-1){1'b0}}, 1'b1};
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SHIFT_LO: begin
            if (div_done_s) begin
               state_nxt_s = SHIFT_HI;
               div_nxt_s   = {DV_W{1'b0}};
            end else begin
               div_nxt_s = div_cnt_r + {{(DV_W-1){1'b0}}, 1'b1};
            end
         end
         SHIFT_HI: begin
            if (div_done_s) begin
               div_nxt_s = {DV_W{1'b0}};
               if (bit_r == {B_W{1'b0}}) begin
                  state_nxt_s = LATCH;
               end else begin
                  bit_nxt_s   = bit_r - {{(B_W-1){1'b0}}, 1'b1};
                  state_nxt_s = SHIFT_LO;
               end
            end else begin
               div_nxt_s = div_cnt_r + {{(DV_W-1){1'b0}}, 1'b1};
            end
         end
         LATCH: begin
            if (div_done_s) begin
               state_nxt_s = IDLE;
               div_nxt_s   = {DV_W{1'b0}};
            end else begin
               div_nxt_s = div_cnt_r + {{(DV_W-1){1'b0}}, 1'b1};
            end
         end
         default: state_nxt_s = IDLE;
      endcase

      ds_nxt_s   = 1'b0;
      shcp_nxt_s = 1'b0;
      stcp_nxt_s = 1'b0;
      case (state_nxt_s)
         SHIFT_LO: ds_nxt_s = frame_nxt_s[bit_nxt_s];
         SHIFT_HI: begin
            ds_nxt_s   = frame_nxt_s[bit_nxt_s];
            shcp_nxt_s = 1'b1;
         end
         LATCH:    stcp_nxt_s = 1'b1;
         default:  ds_nxt_s = 1'b0;
      endcase

      // Display stays dark until the chain holds a complete, latched frame.
      armed_nxt_s = armed_r | ((state_r == LATCH) & div_done_s);
      oe_nxt_s    = armed_nxt_s ? ~bus.disp_en : 1'b1;
   end

   // State, counters and pin registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r    <= IDLE;
         scan_cnt_r <= {SC_W{1'b0}};
         div_cnt_r  <= {DV_W{1'b0}};
         bit_r      <= {B_W{1'b0}};
         k_r        <= {K_W{1'b0}};
         frame_r    <= {W{1'b0}};
         armed_r    <= 1'b0;
         ds_r       <= 1'b0;
         shcp_r     <= 1'b0;
         stcp_r     <= 1'b0;
         oe_r       <= 1'b1;
      end else begin
         state_r    <= state_nxt_s;
         scan_cnt_r <= tick_s ? {SC_W{1'b0}} : scan_cnt_r + {{(SC_W-1){1'b0}}, 1'b1};
         div_cnt_r  <= div_nxt_s;
         bit_r      <= bit_nxt_s;
         k_r        <= k_nxt_s;
         frame_r    <= frame_nxt_s;
         armed_r    <= armed_nxt_s;
         ds_r       <= ds_nxt_s;
         shcp_r     <= shcp_nxt_s;
         stcp_r     <= stcp_nxt_s;
         oe_r       <= oe_nxt_s;
      end
   end

   assign bus.ds   = ds_r;
   assign bus.shcp = shcp_r;
   assign bus.stcp = stcp_r;
   assign bus.oe   = oe_r;
endmodule
